// File: rtl/call_button_input.sv
// Elevator call-button front end: synchronises and debounces the ten raw panel/hall
// buttons, latches them as pending requests and clears them as the car serves each floor.
module call_button_input #(
    parameter int T1MS        = 50000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_car,
    input  logic [2:0] btn_up,
    input  logic [2:0] btn_down,
    input  logic [1:0] now_floor,
    input  logic [1:0] direction,
    input  logic       door_state,
    output logic [3:0] car_req,
    output logic [2:0] up_req,
    output logic [2:0] down_req,
    output logic       req_any,
    output logic       new_req
);

    localparam int NB = 10;
    localparam int TW = $clog2(T1MS + 1);
    localparam int CW = $clog2(DEBOUNCE_MS);
    localparam logic [TW-1:0] TICK_LAST = TW'(T1MS - 1);
    localparam logic [CW-1:0] DCNT_LAST = CW'(DEBOUNCE_MS - 1);

    // Button vector layout: [3:0] car, [6:4] hall up, [9:7] hall down.
    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_db;
    logic [NB-1:0] r_db_d;
    logic [CW-1:0] r_dcnt [NB];
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    logic [NB-1:0] r_req;
    logic          r_req_any;
    logic          r_new_req;

    logic [3:0]    w_clr_car;
    logic [2:0]    w_clr_up;
    logic [2:0]    w_clr_dn;
    logic [NB-1:0] w_clr;
    logic [NB-1:0] w_rise;
    logic [NB-1:0] w_req_nxt;

    assign w_raw  = {btn_down, btn_up, btn_car};
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A disagreement must survive DEBOUNCE_MS ticks in a row; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db   <= '0;
            r_db_d <= '0;
            for (int i = 0; i < NB; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dcnt[i] <= '0;
                end else if (w_tick) begin
                    if (r_dcnt[i] == DCNT_LAST) begin
                        r_db[i]   <= r_sync2[i];
                        r_dcnt[i] <= '0;
                    end else begin
                        r_dcnt[i] <= r_dcnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Calls served at the open door: car always, hall calls only if the car is heading their way.
    always_comb begin
        w_clr_car = '0;
        w_clr_up  = '0;
        w_clr_dn  = '0;
        if (door_state) begin
            w_clr_car[now_floor] = 1'b1;
            if ((now_floor != 2'd3) && (direction != 2'b10)) begin
                w_clr_up[now_floor] = 1'b1;
            end
            if ((now_floor != 2'd0) && (direction != 2'b01)) begin
                w_clr_dn[now_floor - 2'd1] = 1'b1;
            end
        end
    end

    assign w_clr     = {w_clr_dn, w_clr_up, w_clr_car};
    assign w_rise    = r_db & ~r_db_d;
    assign w_req_nxt = (r_req | w_rise) & ~w_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= '0;
            r_req_any <= 1'b0;
            r_new_req <= 1'b0;
        end else begin
            r_req     <= w_req_nxt;
            r_req_any <= |w_req_nxt;
            r_new_req <= |(w_req_nxt & ~r_req);
        end
    end

    assign car_req  = r_req[3:0];
    assign up_req   = r_req[6:4];
    assign down_req = r_req[9:7];
    assign req_any  = r_req_any;
    assign new_req  = r_new_req;

endmodule

// File: doc/call_button_input.md
Name: call_button_input

Overview:
- Input-side counterpart of the floor/direction/door seven-segment display driver.
- Samples the raw car-panel and hall-call push buttons of the 4-floor elevator, synchronises and debounces them, and latches them as pending requests.
- Clears each request automatically when the car is at that floor with the door open.
- Feeds the elevator controller, which supplies now_floor, direction and door_state back in. These use the same encodings the display driver consumes.

Parameters:
- T1MS, 50000, clock cycles per 1 ms tick (50 MHz clk).
- DEBOUNCE_MS, 20, number of consecutive 1 ms ticks a changed level must persist before it is accepted (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- btn_car  input  4  raw car-panel buttons; bit i = floor i+1; active-high, asynchronous
- btn_up  input  3  raw hall "up" buttons; bit i = floor i+1 (floors 1..3)
- btn_down  input  3  raw hall "down" buttons; bit i = floor i+2 (floors 2..4)
- now_floor  input  2  current floor, 00 = floor 1 .. 11 = floor 4
- direction  input  2  00 idle, 01 up, 10 down, 11 treated as idle
- door_state  input  1  1 = door open
- car_req  output  4  pending car requests, same bit mapping as btn_car
- up_req  output  3  pending up calls, same mapping as btn_up
- down_req  output  3  pending down calls, same mapping as btn_down
- req_any  output  1  OR of all request bits (registered)
- new_req  output  1  one-cycle pulse when at least one request bit goes 0->1

Behaviour:
- Reset: all synchroniser flops, debounced levels, debounce counters, tick counter and all outputs are 0.
- Tick generator:
  - tick_cnt counts 0..T1MS-1 and wraps to 0.
  - tick is 1 in the cycle where tick_cnt == T1MS-1.
- Synchroniser: each of the 10 raw buttons passes through two flops (s2 = synchronised level).
- Debounce, per button: debounced level db and a counter dcnt.
  - If s2 == db: dcnt <= 0 in that cycle, whether or not tick is high.
  - Else, on tick: if dcnt == DEBOUNCE_MS-1 then db <= s2 and dcnt <= 0; otherwise dcnt <= dcnt+1.
  - A glitch shorter than one tick window never changes db.
  - Press-to-db latency: (DEBOUNCE_MS-1)*T1MS+3 to DEBOUNCE_MS*T1MS+3 cycles.
- Set: a rising edge of db (db was 0, becomes 1) sets the matching request bit in the next cycle. Holding a button does not re-set a bit after it is cleared; only a fresh press does.
- Clear conditions, evaluated every cycle while door_state == 1, using f = now_floor:
  - car_req[f] <= 0.
  - up_req[f] <= 0 if f <= 2 and direction is 00, 01 or 11.
  - down_req[f-1] <= 0 if f >= 1 and direction is 00, 10 or 11.
- Set and clear on the same bit in the same cycle: clear wins. The call is already being served, and new_req does not pulse for it.
- new_req = 1 for exactly one cycle, the cycle after any bit transitions 0->1. Several simultaneous sets give a single pulse.
- req_any is updated in the same cycle as the request bits.
- Reset mid-operation: all pending requests are lost. In-progress debounce counts are discarded. A button held through reset is re-accepted only after a full debounce window.

Test Plan (sim with T1MS=4, DEBOUNCE_MS=3):
- Reset, then hold btn_car[2]=1 indefinitely, door closed -> car_req becomes 0100 between cycles 11 and 15 after the press; new_req pulses exactly once; req_any=1.
- Pulse btn_up[0] high for 3 cycles only -> up_req stays 000, new_req never asserts.
- car_req=0100 pending, then now_floor=10, door_state=1 -> car_req=0000 the next cycle, req_any=0.
- up_req[1] and down_req[0] pending, now_floor=01, direction=01, door open -> up_req[1] clears, down_req[0] stays 1; switch direction to 00 -> down_req[0] clears.
- now_floor=00, door open, press btn_car[0] -> car_req[0] never sets, new_req stays 0. Simultaneously press btn_car[3] -> car_req=1000 with a single new_req pulse.
- Requests pending, then assert rst for 1 cycle while btn_car[1] is held -> all outputs 0. car_req[1] re-sets only after a full debounce window (at least 11 cycles after rst deasserts).
